uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART serial transmitter. Frame format is 8N1 by default: 1 start bit (0), DBIT data bits sent LSB first, no parity, stop period of SB_TICK ticks (1).
- Bit timing comes from an external oversampling enable `s_tick`, 16 ticks per bit. A shared baud-rate generator drives `s_tick`.
- Sits between the host-side byte interface and the serial `tx` line.

Parameters:
- DBIT, 8, number of data bits per frame (legal range 5..8).
- SB_TICK, 16, number of `s_tick` periods in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_start  input  1  request to send `din`; sampled only in IDLE.
- s_tick  input  1  one-clk-wide enable pulse at 16x the baud rate.
- din  input  8  byte to transmit; only bits [DBIT-1:0] are used.
- tx_done_tick  output  1  one-clk pulse when the stop bit completes.
- tx  output  1  serial line output, registered, idle high.

Behaviour:
- Registers:
  - state: IDLE, START, DATA, STOP.
  - s: 4-bit tick counter.
  - n: 3-bit bit counter.
  - b: 8-bit shift register.
  - tx_reg: drives `tx` directly, so `tx` has no combinational glitches.
- Reset (at a clk edge with reset=1): state=IDLE, s=0, n=0, b=0, tx=1, tx_done_tick=0. Reset aborts any frame in progress immediately; `tx` returns high on the next edge.
- IDLE:
  - Next tx=1.
  - If tx_start=1: capture b<=din, s<=0, go to START.
  - `s_tick` is ignored in IDLE.
- START:
  - Next tx=0.
  - On each s_tick: if s==15, set s<=0, n<=0 and go to DATA; else s<=s+1.
  - The start bit therefore lasts exactly 16 ticks.
- DATA:
  - Next tx=b[0].
  - On s_tick with s==15: s<=0, b<=b>>1. If n==DBIT-1 go to STOP; else n<=n+1.
  - Otherwise, on s_tick: s<=s+1.
- STOP:
  - Next tx=1.
  - On s_tick with s==SB_TICK-1: assert tx_done_tick for that single clk (combinational from state/s/s_tick) and go to IDLE.
  - Otherwise, on s_tick: s<=s+1.
- Clock cycles with s_tick=0 hold s, n and b unchanged in every state.
- Latency:
  - The edge that samples tx_start in IDLE moves state to START.
  - `tx` falls one clk later, because `tx` is registered from the state.
  - Frame length is 16 + 16*DBIT + SB_TICK ticks, i.e. 160 ticks for the defaults.
- Handshake:
  - tx_start is level-sampled and needs only one clk high.
  - tx_start while not in IDLE is ignored, including the tx_done_tick cycle.
  - `din` is captured at the start edge; later changes to `din` do not affect the frame.
  - Back-to-back frames: tx_start held high in the first IDLE cycle after tx_done_tick starts the next frame with no extra idle bit beyond the stop period.
- s_tick coinciding with the tx_start edge is not counted in START.
- Counter widths:
  - s must hold SB_TICK-1: 4 bits for SB_TICK<=16, 5 bits for up to 32, sized via $clog2.
  - n must hold DBIT-1: 3 bits.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, STOP}.
  - OVERSAMPLE=16.
  - default DBIT/SB_TICK constants, reusable by the matching receiver.
- No sub-module. Baud tick generation stays outside this block, and the single FSM is implemented inline.

Test Plan:
- Reset: hold reset 1 clk, no stimulus -> tx=1, tx_done_tick=0, tx_start ignored until reset releases.
- Basic frame:
  - Stimulus: clk 10 ns, s_tick one clk every 164 clks, din=8'h24, tx_start high 2 clks.
  - Required response: tx low for 16 ticks, then bits 0,0,1,0,0,1,0,0 of 16 ticks each, then high for 16 ticks.
  - One tx_done_tick about 262.4 us after start.
- Din stability: change din to 8'h81 mid-frame -> the transmitted bits remain those of 8'h24.
- Busy ignore: pulse tx_start during the DATA state -> no restart and no extra frame; exactly one tx_done_tick.
- Back-to-back: assert tx_start in the clk after tx_done_tick with din=8'hFF, then din=8'h00 -> contiguous frames with exact 16-tick bit boundaries; the start bit immediately follows the 16-tick stop bit.
- Reset mid-frame: assert reset during the 3rd data bit -> tx=1 on the next edge, no tx_done_tick; a new tx_start then sends a full, correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame sequencer states, oversampling ratio and
// default frame shape, common to the transmitter and the matching receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int OVERSAMPLE  = 16;
  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;

  // The tick counter must reach both the per-bit limit and the stop-period limit.
  function automatic int tick_cnt_width(input int sb_tick);
    return (sb_tick > OVERSAMPLE) ? $clog2(sb_tick) : $clog2(OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, SB_TICK-tick stop
// period, all timed by an external 16x oversampling enable.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       s_tick,
  input  logic [7:0] din,
  output logic       tx_done_tick,
  output logic       tx
);

  localparam int SW = tick_cnt_width(SB_TICK);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] START = ST_START;
  localparam logic [1:0] DATA  = ST_DATA;
  localparam logic [1:0] STOP  = ST_STOP;

  localparam logic [SW-1:0] S_ZERO      = {SW{1'b0}};
  localparam logic [SW-1:0] S_ONE       = SW'(1);
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST      = 3'(DBIT - 1);

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [2:0]    n_q, n_d;
  logic [7:0]    b_q, b_d;
  logic          tx_q, tx_d;
  logic          done_s;

  // Frame sequencer: next state, tick/bit counters, shift register and line level.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    tx_d    = 1'b1;
    done_s  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          b_d     = din;
          s_d     = S_ZERO;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = S_ZERO;
            n_d     = 3'd0;
            state_d = DATA;
          end else begin
            s_d = s_q + S_ONE;
          end
        end else begin
          s_d = s_q;
        end
      end
      DATA: begin
        tx_d = b_q[0];
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = S_ZERO;
            b_d = {1'b0, b_q[7:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + S_ONE;
          end
        end else begin
          s_d = s_q;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            done_s  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + S_ONE;
          end
        end else begin
          s_d = s_q;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and line register; reset abandons any frame and parks the line high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= S_ZERO;
      n_q     <= 3'd0;
      b_q     <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
    end
  end

  // A frame cut short by reset never reports completion.
  assign tx_done_tick = done_s & ~reset;
  assign tx           = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a monitor
// decodes the serial line tick by tick and checks shape, data and completion.
module tb_uart_tx;

  localparam int TICK_DIV = 10;
  localparam int BUDGET   = 3000;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       tx_start;
  logic       s_tick;
  logic [7:0] din;
  logic       tx_done_tick;
  logic       tx;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  int   done_cnt;
  int   clk_cnt;
  int   mon_ticks;
  logic in_frame;

  uart_tx dut (
    .clk          (clk),
    .reset        (reset),
    .tx_start     (tx_start),
    .s_tick       (s_tick),
    .din          (din),
    .tx_done_tick (tx_done_tick),
    .tx           (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Oversampling enable: one clk high every TICK_DIV clks.
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  // Expected line level after k ticks consumed since the start edge.
  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k < 16) return 1'b0;
    else if (k < 144) return d[(k - 16) >> 4];
    else return 1'b1;
  endfunction

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input int g);
    exp_t e;
    e.data = d;
    e.gap  = g;
    exp_q.push_back(e);
  endtask

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (mon_ticks < n && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    if (k >= BUDGET) begin
      checks++;
      failures++;
      $display("FAIL wait_ticks: got %0d ticks expected %0d", mon_ticks, n);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    @(negedge clk);
    while (tx_done_tick !== 1'b1 && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= BUDGET) begin
      failures++;
      $display("FAIL wait_done: got no tx_done_tick expected one within %0d clks", BUDGET);
    end
  endtask

  // Monitor: tracks ticks consumed by the DUT (two negedges of lag) and pops the scoreboard.
  initial begin : monitor
    logic       prev_tx;
    logic       prev_st;
    logic       shape_ok;
    logic       done_ok;
    logic [7:0] rx;
    int         c0, c1, c2;
    int         bad_tick;
    int         last_done_clk;
    exp_t       cur;
    prev_tx       = 1'b1;
    prev_st       = 1'b0;
    shape_ok      = 1'b1;
    done_ok       = 1'b1;
    rx            = 8'd0;
    c0 = 0; c1 = 0; c2 = 0;
    bad_tick      = 0;
    last_done_clk = -1000;
    cur.data      = 8'd0;
    cur.gap       = -1;
    forever begin
      @(negedge clk);
      clk_cnt++;
      if (reset) begin
        in_frame = 1'b0;
      end else begin
        if (tx_done_tick === 1'b1) done_cnt++;
        if (!in_frame) begin
          if (tx_done_tick === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL stray_done: got tx_done_tick=1 expected 0 outside a frame");
          end
          if (prev_tx === 1'b1 && tx === 1'b0) begin
            in_frame = 1'b1;
            c2 = 0;
            c1 = int'(prev_st);
            c0 = int'(prev_st) + int'(s_tick);
            shape_ok = 1'b1;
            done_ok  = 1'b1;
            rx       = 8'd0;
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_frame: got a start bit expected an idle line");
              cur.data = 8'd0;
              cur.gap  = -1;
            end else begin
              cur = exp_q.pop_front();
            end
            if (cur.gap >= 0) check_val("b2b_gap_clks", clk_cnt - last_done_clk, cur.gap);
          end
        end else begin
          c2 = c1;
          c1 = c0;
          c0 = c0 + int'(s_tick);
          if (tx !== exp_bit(cur.data, c2)) begin
            if (shape_ok) bad_tick = c2;
            shape_ok = 1'b0;
          end
          if (c2 >= 16 && c2 < 144 && (c2 % 16) == 8) rx[(c2 - 16) >> 4] = tx;
          if (tx_done_tick !== (s_tick && c0 == 160)) done_ok = 1'b0;
          if (c0 == 160) begin
            check_val("frame_data", rx, cur.data);
            check_val("frame_shape_first_bad_tick", shape_ok ? -1 : bad_tick, -1);
            check_val("done_at_tick_160", done_ok, 1);
            if (tx_done_tick === 1'b1) last_done_clk = clk_cnt;
            in_frame = 1'b0;
          end
        end
      end
      mon_ticks = in_frame ? c0 : 0;
      prev_tx   = tx;
      prev_st   = s_tick;
    end
  end

  // Directed stimulus.
  initial begin : stim
    logic ok;
    checks   = 0;
    failures = 0;
    done_cnt = 0;
    clk_cnt  = 0;
    mon_ticks = 0;
    in_frame = 1'b0;
    reset    = 1'b1;
    tx_start = 1'b1;
    din      = 8'hA5;
    @(posedge clk);
    #1 reset = 1'b0;
    tx_start = 1'b0;
    @(negedge clk);
    check_val("reset_tx", tx, 1);
    check_val("reset_done", tx_done_tick, 0);
    ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_done_tick !== 1'b0) ok = 1'b0;
    end
    check_val("idle_after_reset", ok, 1);

    // Basic frame, din changed mid-frame, tx_start pulsed while busy.
    @(posedge clk);
    #1 din = 8'h24;
    push_exp(8'h24, -1);
    tx_start = 1'b1;
    repeat (2) @(posedge clk);
    #1 tx_start = 1'b0;
    wait_ticks(40);
    @(posedge clk);
    #1 din = 8'h81;
    wait_ticks(90);
    @(posedge clk);
    #1 tx_start = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
    wait_done();

    // Back-to-back frames.
    repeat (20) @(posedge clk);
    #1 din = 8'hFF;
    push_exp(8'hFF, -1);
    tx_start = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
    wait_done();
    @(posedge clk);
    #1 din = 8'h00;
    push_exp(8'h00, 3);
    tx_start = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
    wait_done();

    // Reset during the third data bit, then a clean frame.
    repeat (20) @(posedge clk);
    #1 din = 8'h3C;
    push_exp(8'h3C, -1);
    tx_start = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
    wait_ticks(56);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("tx_after_midframe_reset", tx, 1);
    check_val("done_after_midframe_reset", tx_done_tick, 0);
    repeat (5) @(posedge clk);
    #1 din = 8'hC3;
    push_exp(8'hC3, -1);
    tx_start = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
    wait_done();

    repeat (10) @(posedge clk);
    @(negedge clk);
    check_val("total_done_ticks", done_cnt, 4);
    check_val("scoreboard_left", exp_q.size(), 0);
    check_val("monitor_idle", in_frame, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
